// File: rtl/muldiv_unit_if.sv
// Request/response bundle between issue logic and the multi-cycle mul/div unit.
interface muldiv_unit_if #(parameter int XLEN = 64);
  logic            IN_VALID;
  logic            IN_READY;
  logic [XLEN-1:0] X;
  logic [XLEN-1:0] Y;
  logic [3:0]      OP;
  logic            KILL;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] OUTPUT;

  modport master (output IN_VALID, X, Y, OP, KILL, OUT_READY,
                  input  IN_READY, OUT_VALID, OUTPUT);
  modport slave  (input  IN_VALID, X, Y, OP, KILL, OUT_READY,
                  output IN_READY, OUT_VALID, OUTPUT);
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV64M mul/div responder: radix-2 shift-add / restoring divide, XLEN iterations.
// Define MULDIV_WORD_OPS_EN to enable the RV64 W variants (OP 8, 12-15).
module muldiv_unit #(parameter int XLEN = 64) (
  input logic          CLK,
  input logic          RESET,
  muldiv_unit_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN64 = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN32 = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  state_t          state_q, state_d;
  logic [XLEN-1:0] x_q, y_q, hi_q, lo_q, res_q;
  logic [3:0]      op_q;
  logic [6:0]      cnt_q;
  logic            q_neg, r_neg;

  // Op decode
  logic is_div, is_word, is_illegal;
  assign is_div = op_q[2];
`ifdef MULDIV_WORD_OPS_EN
  assign is_word    = op_q[3];
  assign is_illegal = op_q[3] & ~op_q[2] & (op_q[1:0] != 2'b00);
`else
  assign is_word    = 1'b0;
  assign is_illegal = op_q[3];
`endif

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand preparation: word ops narrow first, then signed ops take magnitudes
  logic            ext_sgn, x_sgn, y_sgn, sx, sy;
  logic [XLEN-1:0] xe, ye, xa, ya;
  assign ext_sgn = ~(is_div & op_q[0]);
  assign xe = is_word ? {{(XLEN-32){ext_sgn & x_q[31]}}, x_q[31:0]} : x_q;
  assign ye = is_word ? {{(XLEN-32){ext_sgn & y_q[31]}}, y_q[31:0]} : y_q;
  assign x_sgn = is_div ? ~op_q[0] : (op_q[1:0] == 2'd1 || op_q[1:0] == 2'd2);
  assign y_sgn = is_div ? ~op_q[0] : (op_q[1:0] == 2'd1);
  assign sx = x_sgn & xe[XLEN-1];
  assign sy = y_sgn & ye[XLEN-1];
  assign xa = sx ? -xe : xe;
  assign ya = sy ? -ye : ye;

  logic div_zero, ovf, fast;
  logic [XLEN-1:0] fast_res;
  assign div_zero = is_div & ~is_illegal & (ye == '0);
  assign ovf      = is_div & ~is_illegal & ~op_q[0] & (&ye) &
                    (xe == (is_word ? MIN32 : MIN64));
  assign fast     = is_illegal | div_zero | ovf;

  always_comb begin
    fast_res = '0;
    if (is_illegal)    fast_res = '0;
    else if (div_zero) fast_res = op_q[1] ? xe : '1;
    else if (ovf)      fast_res = op_q[1] ? '0 : xe;
  end

  // One radix-2 step: hi_q is the upper product / partial remainder
  logic [XLEN:0]   mul_sum, div_sh;
  logic [XLEN-1:0] div_sub;
  logic            div_ge;
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, x_q} : {(XLEN+1){1'b0}});
  assign div_sh  = {hi_q, lo_q[XLEN-1]};
  assign div_ge  = div_sh >= {1'b0, y_q};
  assign div_sub = div_sh[XLEN-1:0] - y_q;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_res, quo, rem, fix_res;
  assign prod_s  = q_neg ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign mul_res = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  assign quo     = q_neg ? -lo_q : lo_q;
  assign rem     = r_neg ? -hi_q : hi_q;
  assign fix_res = wfix(is_word, is_div ? (op_q[1] ? rem : quo) : mul_res);

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.IN_VALID && !bus.KILL) state_d = S_PREP;
      S_PREP:  state_d = fast ? S_DONE : S_ITER;
      S_ITER:  if (cnt_q == 7'd1) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  if (bus.OUT_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.KILL && state_q != S_IDLE) state_d = S_IDLE;
  end

  assign bus.IN_READY  = (state_q == S_IDLE);
  assign bus.OUT_VALID = (state_q == S_DONE) && !bus.KILL;
  assign bus.OUTPUT    = res_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_q   <= '0;
      y_q   <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      res_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.IN_VALID && !bus.KILL) begin
          x_q  <= bus.X;
          y_q  <= bus.Y;
          op_q <= bus.OP;
        end
        S_PREP: begin
          x_q   <= xa;
          y_q   <= ya;
          hi_q  <= '0;
          lo_q  <= is_div ? xa : ya;
          q_neg <= sx ^ sy;
          r_neg <= sx;
          cnt_q <= 7'(XLEN);
          if (fast) res_q <= wfix(is_word, fast_res);
        end
        S_ITER: begin
          cnt_q <= cnt_q - 7'd1;
          if (is_div) begin
            hi_q <= div_ge ? div_sub : div_sh[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], div_ge};
          end else begin
            {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
          end
        end
        S_FIX:   res_q <= fix_res;
        default: ;
      endcase
    end
  end
endmodule
